// File: rtl/counter_pkg.sv
// Shared definitions for the counter/timer group: FSM state encoding and
// default width/limit used by both the up-counter and the countdown timer.
package counter_pkg;

  localparam int unsigned CNT_WIDTH = 8;
  localparam int unsigned CNT_MAX   = 100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } cnt_state_t;

endpackage

// File: rtl/countdown_timer_prescaler.sv
// Free-running 0..DIV-1 prescaler; tick is decoded straight from the register
// so it adds no latency, and with DIV = 1 it reduces to tick = en.
module tick_prescaler #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable saturating down-counter with prescaled decrement, start/pause/load
// FSM and a one-cycle done pulse at terminal count. State updates on negedge.
module countdown_timer
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH,
  parameter int unsigned MAX   = CNT_MAX,
  parameter int unsigned DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  cnt_state_t       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             pre_en, pre_clr, tick;
  logic [WIDTH-1:0] load_clamped;

  assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

  // A resume from HOLD advances the prescaler on the same edge, so time spent
  // in HOLD is the only delay added to the countdown.
  assign pre_en = !load && !pause &&
                  ((state_q == ST_RUN) || ((state_q == ST_HOLD) && start));
  assign pre_clr = (state_d == ST_IDLE) || (state_d == ST_DONE);

  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    if (load) begin
      state_d = ST_IDLE;
      count_d = load_clamped;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (count_q == '0) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN, ST_HOLD: begin
          if (pause) begin
            state_d = ST_HOLD;
          end else if (state_q == ST_RUN || start) begin
            state_d = ST_RUN;
          end
          if (pre_en && tick) begin
            count_d = (count_q == '0) ? '0 : count_q - ONE_V;
            if (count_q <= ONE_V) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= MAX_V;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign busy  = (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign done  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: one DIV=1 and one DIV=3 instance share
// stimulus; outputs are sampled on the rising edge, opposite the active edge.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = '0;
  logic       start = 1'b0;
  logic       pause = 1'b0;

  logic [7:0] c1, c3;
  logic       b1, b3, d1, d3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(8), .MAX(100), .DIV(1)) u1 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .count(c1), .busy(b1), .done(d1)
  );

  countdown_timer #(.WIDTH(8), .MAX(100), .DIV(3)) u3 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .count(c3), .busy(b3), .done(d3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One active (falling) edge, then park on the following rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      @(posedge clk);
    end
  endtask

  initial begin
    // Reset then idle
    #1 rst = 1'b1;
    #1;
    chk("rst_async_count", 32'(c1), 100);
    step(2);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("idle_count", 32'(c1), 100);
      chk("idle_busy", 32'(b1), 0);
      chk("idle_done", 32'(d1), 0);
    end

    // Basic countdown, DIV = 1
    load = 1'b1; load_val = 8'd5;
    step(1);
    load = 1'b0;
    chk("load5_count", 32'(c1), 5);
    chk("load5_busy", 32'(b1), 0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("start_busy", 32'(b1), 1);
    chk("start_count", 32'(c1), 5);
    for (int k = 4; k >= 0; k--) begin
      step(1);
      chk("cd_count", 32'(c1), 32'(k));
      chk("cd_done", 32'(d1), (k == 0) ? 1 : 0);
      chk("cd_busy", 32'(b1), (k == 0) ? 0 : 1);
    end
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("zero_hold_count", 32'(c1), 0);
      chk("zero_hold_done", 32'(d1), 0);
    end
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("done_start_busy", 32'(b1), 0);
    chk("done_start_done", 32'(d1), 0);

    // Clamp and prescale, DIV = 3
    load = 1'b1; load_val = 8'd200;
    step(1);
    load = 1'b0;
    chk("clamp_count", 32'(c3), 100);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("div3_busy", 32'(b3), 1);
    chk("div3_count0", 32'(c3), 100);
    for (int i = 1; i <= 300; i++) begin
      step(1);
      chk("div3_count", 32'(c3), 32'(100 - i / 3));
      chk("div3_done", 32'(d3), (i == 300) ? 1 : 0);
    end
    chk("div3_busy_end", 32'(b3), 0);

    // Pause and resume, DIV = 1: done 7 edges later than edge N+10
    load = 1'b1; load_val = 8'd10;
    step(1);
    load = 1'b0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(4);
    chk("pre_pause_count", 32'(c1), 6);
    pause = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step(1);
      chk("hold_count", 32'(c1), 6);
      chk("hold_busy", 32'(b1), 1);
      chk("hold_done", 32'(d1), 0);
    end
    pause = 1'b0; start = 1'b1;
    step(1);
    start = 1'b0;
    chk("resume_count", 32'(c1), 5);
    for (int k = 4; k >= 0; k--) begin
      step(1);
      chk("resume_cd", 32'(c1), 32'(k));
      chk("resume_done", 32'(d1), (k == 0) ? 1 : 0);
    end

    // load + start together: IDLE with new value
    load = 1'b1; load_val = 8'd9; start = 1'b1;
    step(1);
    load = 1'b0; start = 1'b0;
    chk("ld_st_count", 32'(c1), 9);
    chk("ld_st_busy", 32'(b1), 0);
    step(1);
    chk("ld_st_idle_count", 32'(c1), 9);
    // pause + start in RUN -> HOLD
    start = 1'b1;
    step(1);
    pause = 1'b1;
    step(1);
    pause = 1'b0; start = 1'b0;
    chk("ps_run_count", 32'(c1), 9);
    step(1);
    chk("ps_hold_count", 32'(c1), 9);
    chk("ps_hold_busy", 32'(b1), 1);
    pause = 1'b1; start = 1'b1;
    step(1);
    chk("hold_ps_count", 32'(c1), 9);
    pause = 1'b0;
    step(1);
    start = 1'b0;
    chk("hold_resume_count", 32'(c1), 8);
    // start with count = 0 -> immediate done
    load = 1'b1; load_val = 8'd0;
    step(1);
    load = 1'b0;
    chk("load0_count", 32'(c1), 0);
    chk("load0_done", 32'(d1), 0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("zero_start_done", 32'(d1), 1);
    chk("zero_start_busy", 32'(b1), 0);
    step(1);
    chk("zero_start_done_clr", 32'(d1), 0);

    // Asynchronous reset mid-count
    load = 1'b1; load_val = 8'd50;
    step(1);
    load = 1'b0; start = 1'b1;
    step(1);
    start = 1'b0;
    step(13);
    chk("pre_rst_count", 32'(c1), 37);
    rst = 1'b1;
    #1;
    chk("arst_count", 32'(c1), 100);
    chk("arst_busy", 32'(b1), 0);
    chk("arst_done", 32'(d1), 0);
    #1 rst = 1'b0;
    step(1);
    chk("post_rst_count", 32'(c1), 100);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("post_rst_busy", 32'(b1), 1);
    step(2);
    chk("post_rst_cd", 32'(c1), 98);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable, saturating down-counter that complements the team's 0-to-100 saturating up-counter: it counts from a loaded value down to zero and stops there. A prescaler sets the decrement rate. Start, pause and load controls drive a four-state FSM, and a one-cycle `done` pulse marks terminal count. It sits beside the up-counter in the counter/timer group and feeds timeouts to control logic.

## Interface
- `WIDTH`, 8: count width in bits.
- `MAX`, 100: largest loadable value; must be ≤ 2^WIDTH−1.
- `DIV`, 1: prescaler ratio, ≥1; one decrement every `DIV` active cycles.
- `clk` input 1: clock; all state updates on the falling edge.
- `rst` input 1: asynchronous, active-high reset.
- `load` input 1: load `load_val` into `count`; enters IDLE.
- `load_val` input WIDTH: value to load; values > `MAX` clamp to `MAX`.
- `start` input 1: begin or resume counting.
- `pause` input 1: freeze counting while in RUN.
- `count` output WIDTH: current value.
- `busy` output 1: high in RUN or HOLD.
- `done` output 1: one-cycle pulse when `count` reaches 0 in RUN.

## Operation
- Reset values:
  - `count` = `MAX`, `busy` = 0, `done` = 0, state = IDLE, prescaler = 0.
- FSM states: IDLE, RUN, HOLD, DONE.
- Transitions:
  - IDLE: `start` and `count` ≠ 0 → RUN. `start` with `count` = 0 → DONE, and `done` pulses.
  - RUN: `pause` → HOLD. Prescaler tick with `count` = 1 → DONE.
  - HOLD: `start` → RUN. `pause` has no effect.
  - DONE: stays until `load`; `start` is ignored.
- Priority: `rst` > `load` > `pause` > `start`. With `pause` and `start` together in RUN, go to HOLD. In HOLD, `start` wins only if `pause` is low.
- `load` in any state:
  - `count` ← min(`load_val`, `MAX`), prescaler cleared, state → IDLE.
  - Any tick in that same cycle is discarded.
- Decrement:
  - Occurs only in RUN, on a prescaler tick.
  - `count` never wraps below 0: saturating unsigned subtract.
- Prescaler:
  - Counts 0..`DIV`−1 in RUN only; tick when it equals `DIV`−1.
  - Holds its value in HOLD.
  - Cleared on entering IDLE or DONE.
- `done`:
  - Asserted for exactly one cycle, on the edge where `count` becomes 0 (or IDLE→DONE with `count` = 0).
  - Never re-asserted in DONE.
- Asynchronous `rst` mid-count returns all outputs to reset values immediately, without waiting for a clock edge.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- `start` sampled at falling edge N gives `busy` = 1 after edge N.
- With `DIV` = 1, the first decrement is at edge N+1.
- Load L (1 ≤ L ≤ `MAX`), `DIV` = D, `start` at edge N:
  - `count` = 0 and `done` = 1 after edge N + L·D.
  - `busy` = 0 from that same edge.
- HOLD adds exactly the number of cycles spent in HOLD; there is no extra latency on resume.
- `load` takes effect at the edge where it is sampled.

## Structure
- Shared package `counter_pkg` holds:
  - the FSM state enum (IDLE, RUN, HOLD, DONE, 2-bit encoding);
  - default constants `CNT_WIDTH` = 8 and `CNT_MAX` = 100, also used by the up-counter.
- Sub-module `tick_prescaler` (parameter `DIV`):
  - inputs `clk`, `rst`, `en`, `clr`; output `tick`;
  - `tick` is combinational from its register, so there is no added cycle.
  - When `DIV` = 1, `tick` = `en`.
- Top level holds the FSM, count register, clamp and `done` pulse logic.

## Test plan
- Reset then idle:
  - Stimulus: `rst` high then released, no inputs.
  - Required: `count` = 100, `busy` = 0, `done` = 0, holding for 20 cycles.
- Basic countdown (`DIV` = 1):
  - Stimulus: load 5, `start`.
  - Required: `count` 4,3,2,1,0 on successive edges; `done` high one cycle at 0; `busy` low after; `count` holds 0 for 10 more cycles.
- Clamp and prescale (`DIV` = 3):
  - Stimulus: `load_val` = 200, `start`.
  - Required: `count` = 100 after load; decrements every 3 cycles; `done` after 300 cycles.
- Pause and resume:
  - Stimulus: load 10, `start`; `pause` at `count` = 6 for 7 cycles; then `start`.
  - Required: `count` holds 6; `done` arrives exactly 7 cycles later than the unpaused run.
- Simultaneous events:
  - `load` and `start` in the same cycle → IDLE with the new value, not running.
  - `pause` and `start` in RUN → HOLD.
  - `start` with `count` = 0 → immediate `done` pulse, state DONE.
- Asynchronous reset mid-count:
  - Stimulus: assert `rst` between clock edges at `count` = 37.
  - Required: `count` = 100 and `busy` = 0 before the next edge; after release, `start` counts down from 100.
